// File: rtl/lsu_stage.sv
// ---------------------------------------------------------------------------
// lsu_stage -- load/store unit stage of the 5-stage RV32E pipeline.
//
// Takes one instruction at a time from EXU. Loads and stores run over a split
// AXI4-Lite-style master port; everything else passes straight through. The
// writeback value (load data aligned and extended, ALU result, or 0 for
// stores) and the instruction context are then offered to WBU with a
// valid/ready handshake.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   in_valid / in_ready   EXU handshake; in_ready is high only while IDLE
//   in_inst               instruction word (opcode/funct3 decoded here)
//   in_alu_result         effective address for memory ops, else result
//   in_store_data         rs2 value for stores
//   in_next_pc, in_num    next PC and instruction sequence number
//   mem_ar* / mem_r*      read address / read data channels
//   mem_aw* / mem_w*      write address / write data channels
//   mem_b*                write response channel
//   out_valid / out_ready WBU handshake
//   out_wdata             writeback value
//   out_inst, out_next_pc, out_num   latched instruction context
//   out_sim_lsu_addr      effective address for loads/stores, 0 otherwise
//   out_fault             (LSU_ACCESS_FAULT_EN only) nonzero rresp/bresp
//
// Build option:
//   LSU_ACCESS_FAULT_EN   adds out_fault; a faulting load writes back 0.
//                         Without it, mem_rresp and mem_bresp are ignored.
// ---------------------------------------------------------------------------
module lsu_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WIDTH  = 64
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_store_data,
  input  logic [ADDR_WIDTH-1:0] in_next_pc,
  input  logic [NUM_WIDTH-1:0]  in_num,

  output logic                  mem_arvalid,
  input  logic                  mem_arready,
  output logic [ADDR_WIDTH-1:0] mem_araddr,
  input  logic                  mem_rvalid,
  output logic                  mem_rready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [1:0]            mem_rresp,

  output logic                  mem_awvalid,
  input  logic                  mem_awready,
  output logic [ADDR_WIDTH-1:0] mem_awaddr,
  output logic                  mem_wvalid,
  input  logic                  mem_wready,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_bvalid,
  output logic                  mem_bready,
  input  logic [1:0]            mem_bresp,

  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_wdata,
  output logic [31:0]           out_inst,
  output logic [ADDR_WIDTH-1:0] out_next_pc,
  output logic [NUM_WIDTH-1:0]  out_num,
  output logic [ADDR_WIDTH-1:0] out_sim_lsu_addr
`ifdef LSU_ACCESS_FAULT_EN
  ,
  output logic                  out_fault
`endif
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    accept;
  logic                    aw_done;
  logic                    w_done;

  // Select and extend the addressed lane of a read word. Unused funct3
  // encodings fall back to a whole-word load.
  function automatic logic [31:0] load_align(input logic [2:0]  f3,
                                             input logic [1:0]  a,
                                             input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{a, 3'b000} +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  load_align = {{24{b[7]}}, b};
      3'b001:  load_align = {{16{h[15]}}, h};
      3'b100:  load_align = {24'b0, b};
      3'b101:  load_align = {16'b0, h};
      default: load_align = d;
    endcase
  endfunction

  // Move store data onto the byte lanes it targets; other lanes are zero.
  function automatic logic [31:0] store_lanes(input logic [2:0]  f3,
                                              input logic [1:0]  a,
                                              input logic [31:0] d);
    case (f3)
      3'b000:  store_lanes = {24'b0, d[7:0]} << {a, 3'b000};
      3'b001:  store_lanes = {16'b0, d[15:0]} << {a[1], 4'b0000};
      default: store_lanes = d;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3,
                                            input logic [1:0] a);
    case (f3)
      3'b000:  store_strb = 4'b0001 << a;
      3'b001:  store_strb = 4'b0011 << {a[1], 1'b0};
      default: store_strb = 4'b1111;
    endcase
  endfunction

  assign in_ready   = (state == IDLE);
  assign accept     = (state == IDLE) && in_valid;
  assign mem_araddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_awaddr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  // A write channel counts as done once its valid has dropped or it is
  // handshaking this cycle; AW and W may finish in either order.
  assign aw_done = !mem_awvalid || mem_awready;
  assign w_done  = !mem_wvalid  || mem_wready;

`ifndef LSU_ACCESS_FAULT_EN
  logic unused_resp;
  assign unused_resp = ^{mem_rresp, mem_bresp};
`endif

  // Datapath registers that never need a reset value: effective address and
  // the store beat, captured when an instruction is accepted.
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_q    <= in_alu_result[ADDR_WIDTH-1:0];
      mem_wdata <= store_lanes(in_inst[14:12], in_alu_result[1:0], in_store_data);
      mem_wstrb <= store_strb(in_inst[14:12], in_alu_result[1:0]);
    end
  end

  // Control FSM and WBU-facing output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      mem_arvalid      <= 1'b0;
      mem_rready       <= 1'b0;
      mem_awvalid      <= 1'b0;
      mem_wvalid       <= 1'b0;
      mem_bready       <= 1'b0;
      out_valid        <= 1'b0;
      out_wdata        <= '0;
      out_inst         <= '0;
      out_next_pc      <= '0;
      out_num          <= '0;
      out_sim_lsu_addr <= '0;
`ifdef LSU_ACCESS_FAULT_EN
      out_fault        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_inst    <= in_inst;
            out_next_pc <= in_next_pc;
            out_num     <= in_num;
`ifdef LSU_ACCESS_FAULT_EN
            out_fault   <= 1'b0;
`endif
            case (in_inst[6:0])
              OPC_LOAD: begin
                state            <= RD_ADDR;
                mem_arvalid      <= 1'b1;
                out_wdata        <= '0;
                out_sim_lsu_addr <= in_alu_result[ADDR_WIDTH-1:0];
              end
              OPC_STORE: begin
                state            <= WR_REQ;
                mem_awvalid      <= 1'b1;
                mem_wvalid       <= 1'b1;
                out_wdata        <= '0;
                out_sim_lsu_addr <= in_alu_result[ADDR_WIDTH-1:0];
              end
              default: begin
                state            <= DONE;
                out_valid        <= 1'b1;
                out_wdata        <= in_alu_result;
                out_sim_lsu_addr <= '0;
              end
            endcase
          end
        end

        RD_ADDR: begin
          if (mem_arready) begin
            mem_arvalid <= 1'b0;
            mem_rready  <= 1'b1;
            state       <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (mem_rvalid) begin
            mem_rready <= 1'b0;
            out_valid  <= 1'b1;
            state      <= DONE;
            out_wdata  <= load_align(out_inst[14:12], addr_q[1:0], mem_rdata);
`ifdef LSU_ACCESS_FAULT_EN
            if (mem_rresp != 2'b00) begin
              out_fault <= 1'b1;
              out_wdata <= '0;
            end
`endif
          end
        end

        WR_REQ: begin
          if (mem_awvalid && mem_awready) mem_awvalid <= 1'b0;
          if (mem_wvalid && mem_wready)   mem_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            mem_bready <= 1'b1;
            state      <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (mem_bvalid) begin
            mem_bready <= 1'b0;
            out_valid  <= 1'b1;
            state      <= DONE;
`ifdef LSU_ACCESS_FAULT_EN
            if (mem_bresp != 2'b00) out_fault <= 1'b1;
`endif
          end
        end

        DONE: begin
          // Outputs hold until WBU takes them; the next instruction is only
          // accepted from IDLE, one cycle after this handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
module tb_lsu_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_alu_result;
  logic [31:0] in_store_data;
  logic [31:0] in_next_pc;
  logic [63:0] in_num;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [31:0] mem_araddr;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_awvalid;
  logic        mem_awready;
  logic [31:0] mem_awaddr;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_bvalid;
  logic        mem_bready;
  logic [1:0]  mem_bresp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_wdata;
  logic [31:0] out_inst;
  logic [31:0] out_next_pc;
  logic [63:0] out_num;
  logic [31:0] out_sim_lsu_addr;
`ifdef LSU_ACCESS_FAULT_EN
  logic        out_fault;
`endif

  always #5 clock = ~clock;

  lsu_stage dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_inst          (in_inst),
    .in_alu_result    (in_alu_result),
    .in_store_data    (in_store_data),
    .in_next_pc       (in_next_pc),
    .in_num           (in_num),
    .mem_arvalid      (mem_arvalid),
    .mem_arready      (mem_arready),
    .mem_araddr       (mem_araddr),
    .mem_rvalid       (mem_rvalid),
    .mem_rready       (mem_rready),
    .mem_rdata        (mem_rdata),
    .mem_rresp        (mem_rresp),
    .mem_awvalid      (mem_awvalid),
    .mem_awready      (mem_awready),
    .mem_awaddr       (mem_awaddr),
    .mem_wvalid       (mem_wvalid),
    .mem_wready       (mem_wready),
    .mem_wdata        (mem_wdata),
    .mem_wstrb        (mem_wstrb),
    .mem_bvalid       (mem_bvalid),
    .mem_bready       (mem_bready),
    .mem_bresp        (mem_bresp),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_wdata        (out_wdata),
    .out_inst         (out_inst),
    .out_next_pc      (out_next_pc),
    .out_num          (out_num),
    .out_sim_lsu_addr (out_sim_lsu_addr)
`ifdef LSU_ACCESS_FAULT_EN
    ,
    .out_fault        (out_fault)
`endif
  );

  localparam int K_ALU = 0;
  localparam int K_LD  = 1;
  localparam int K_ST  = 2;

  typedef struct {
    int          kind;
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [31:0] exp_wdata;
    logic [31:0] exp_bus_addr;
    logic [31:0] exp_mem_wdata;
    logic [3:0]  exp_wstrb;
  } vec_t;

  vec_t vecs[14];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) chk("wait in_ready timeout", 64'(in_ready), 64'd1);
  endtask

  // Present one instruction for a single cycle; returns at the negedge of
  // the cycle after acceptance.
  task automatic accept(input logic [31:0] inst, input logic [31:0] addr,
                        input logic [31:0] sdata, input int idx);
    wait_idle();
    in_valid      = 1'b1;
    in_inst       = inst;
    in_alu_result = addr;
    in_store_data = sdata;
    in_next_pc    = 32'h0000_1000 + 32'(idx) * 32'd4;
    in_num        = 64'(idx) + 64'd100;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Zero-wait slave for R and B: answers in the cycle after ready rises.
  task automatic serve(input logic [31:0] rdata, input logic [1:0] resp, output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      mem_rvalid = mem_rready;
      mem_rdata  = rdata;
      mem_rresp  = resp;
      mem_bvalid = mem_bready;
      @(negedge clock);
      lat++;
    end
    mem_rvalid = 1'b0;
    mem_bvalid = 1'b0;
    mem_rresp  = 2'b00;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    out_ready = 1'b1;
    accept(v.inst, v.addr, v.sdata, idx);
    case (v.kind)
      K_ALU: begin
        chk($sformatf("v%0d alu out_valid", idx), 64'(out_valid), 64'd1);
        chk($sformatf("v%0d alu no bus", idx),
            64'({mem_arvalid, mem_awvalid, mem_wvalid}), 64'd0);
      end
      K_LD: begin
        chk($sformatf("v%0d arvalid", idx), 64'(mem_arvalid), 64'd1);
        chk($sformatf("v%0d araddr", idx), 64'(mem_araddr), 64'(v.exp_bus_addr));
      end
      default: begin
        chk($sformatf("v%0d aw/w valid", idx), 64'({mem_awvalid, mem_wvalid}), 64'd3);
        chk($sformatf("v%0d awaddr", idx), 64'(mem_awaddr), 64'(v.exp_bus_addr));
        chk($sformatf("v%0d mem_wdata", idx), 64'(mem_wdata), 64'(v.exp_mem_wdata));
        chk($sformatf("v%0d wstrb", idx), 64'(mem_wstrb), 64'(v.exp_wstrb));
      end
    endcase
    serve(v.rdata, 2'b00, lat);
    chk($sformatf("v%0d latency", idx), 64'(lat), (v.kind == K_ALU) ? 64'd1 : 64'd3);
    chk($sformatf("v%0d out_wdata", idx), 64'(out_wdata), 64'(v.exp_wdata));
    chk($sformatf("v%0d out_inst", idx), 64'(out_inst), 64'(v.inst));
    chk($sformatf("v%0d out_next_pc", idx), 64'(out_next_pc), 64'(32'h0000_1000 + 32'(idx) * 32'd4));
    chk($sformatf("v%0d out_num", idx), out_num, 64'(idx) + 64'd100);
    chk($sformatf("v%0d sim_lsu_addr", idx), 64'(out_sim_lsu_addr),
        (v.kind == K_ALU) ? 64'd0 : 64'(v.addr));
    @(negedge clock);
    chk($sformatf("v%0d back to idle", idx), 64'({in_ready, out_valid}), 64'b10);
  endtask

  initial begin
    int lat;

    //        kind   inst           addr           sdata          rdata          exp_wdata      bus_addr       mem_wdata      strb
    vecs[0]  = '{K_ALU, 32'h1234_0093, 32'h0000_1234, 32'h0,         32'h0,         32'h0000_1234, 32'h0,         32'h0,         4'h0};
    vecs[1]  = '{K_LD,  32'h0000_8083, 32'h8000_0003, 32'h0,         32'h80AB_CDEF, 32'hFFFF_FF80, 32'h8000_0000, 32'h0,         4'h0};
    vecs[2]  = '{K_LD,  32'h0000_C083, 32'h8000_0003, 32'h0,         32'h80AB_CDEF, 32'h0000_0080, 32'h8000_0000, 32'h0,         4'h0};
    vecs[3]  = '{K_LD,  32'h0000_D083, 32'h8000_0002, 32'h0,         32'h1234_5678, 32'h0000_1234, 32'h8000_0000, 32'h0,         4'h0};
    vecs[4]  = '{K_LD,  32'h0000_9083, 32'h8000_0002, 32'h0,         32'h8765_0000, 32'hFFFF_8765, 32'h8000_0000, 32'h0,         4'h0};
    vecs[5]  = '{K_LD,  32'h0000_A083, 32'h8000_0007, 32'h0,         32'hCAFE_BABE, 32'hCAFE_BABE, 32'h8000_0004, 32'h0,         4'h0};
    vecs[6]  = '{K_LD,  32'h0000_8083, 32'h8000_0001, 32'h0,         32'h0000_7F00, 32'h0000_007F, 32'h8000_0000, 32'h0,         4'h0};
    vecs[7]  = '{K_LD,  32'h0000_9083, 32'h8000_0001, 32'h0,         32'h1234_F00D, 32'hFFFF_F00D, 32'h8000_0000, 32'h0,         4'h0};
    vecs[8]  = '{K_ST,  32'h0010_8023, 32'h8000_0001, 32'hDEAD_BEEF, 32'h0,         32'h0,         32'h8000_0000, 32'h0000_EF00, 4'b0010};
    vecs[9]  = '{K_ST,  32'h0010_9023, 32'h8000_0006, 32'hDEAD_BEEF, 32'h0,         32'h0,         32'h8000_0004, 32'hBEEF_0000, 4'b1100};
    vecs[10] = '{K_ST,  32'h0010_A023, 32'h8000_0003, 32'h1234_5678, 32'h0,         32'h0,         32'h8000_0000, 32'h1234_5678, 4'b1111};
    vecs[11] = '{K_ST,  32'h0010_8023, 32'h8000_0003, 32'h0000_00A5, 32'h0,         32'h0,         32'h8000_0000, 32'hA500_0000, 4'b1000};
    vecs[12] = '{K_ALU, 32'h1234_50B7, 32'h1234_5000, 32'h0,         32'h0,         32'h1234_5000, 32'h0,         32'h0,         4'h0};
    vecs[13] = '{K_LD,  32'h0000_B083, 32'h8000_0002, 32'h0,         32'h55AA_55AA, 32'h55AA_55AA, 32'h8000_0000, 32'h0,         4'h0};

    reset = 1'b1;
    in_valid = 1'b0; in_inst = '0; in_alu_result = '0; in_store_data = '0;
    in_next_pc = '0; in_num = '0;
    mem_arready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = 2'b00;
    mem_awready = 1'b1; mem_wready = 1'b1; mem_bvalid = 1'b0; mem_bresp = 2'b00;
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset valids", 64'({out_valid, mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready}), 64'd0);
    chk("reset out_wdata", 64'(out_wdata), 64'd0);
    chk("reset out ctx", 64'(out_inst | out_next_pc | out_sim_lsu_addr), 64'd0);
    chk("reset out_num", out_num, 64'd0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // SB with AW held off for three cycles while W completes at once.
    mem_awready = 1'b0;
    accept(32'h0010_8023, 32'h8000_0001, 32'hDEAD_BEEF, 40);
    chk("sb dly aw/w valid", 64'({mem_awvalid, mem_wvalid}), 64'd3);
    chk("sb dly wstrb", 64'(mem_wstrb), 64'b0010);
    chk("sb dly wdata", 64'(mem_wdata), 64'h0000_EF00);
    @(negedge clock);
    chk("sb dly c2 aw,w,b", 64'({mem_awvalid, mem_wvalid, mem_bready}), 64'b100);
    @(negedge clock);
    chk("sb dly c3 aw,w,b", 64'({mem_awvalid, mem_wvalid, mem_bready}), 64'b100);
    mem_awready = 1'b1;
    @(negedge clock);
    chk("sb dly c4 aw,b,outv", 64'({mem_awvalid, mem_bready, out_valid}), 64'b010);
    mem_bvalid = 1'b1;
    @(negedge clock);
    mem_bvalid = 1'b0;
    chk("sb dly done outv,b", 64'({out_valid, mem_bready}), 64'b10);
    chk("sb dly out_wdata", 64'(out_wdata), 64'd0);
    @(negedge clock);
    chk("sb dly idle", 64'(in_ready), 64'd1);

    // Back-pressure from WBU while a load result waits in DONE.
    out_ready = 1'b0;
    accept(32'h0000_A083, 32'h8000_0010, 32'h0, 50);
    serve(32'h1122_3344, 2'b00, lat);
    chk("bp latency", 64'(lat), 64'd3);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp c%0d valid/ready", c), 64'({out_valid, in_ready}), 64'b10);
      chk($sformatf("bp c%0d wdata", c), 64'(out_wdata), 64'h1122_3344);
      chk($sformatf("bp c%0d ctx", c), {out_next_pc, out_sim_lsu_addr}, {32'h0000_10C8, 32'h8000_0010});
      chk($sformatf("bp c%0d num/inst", c), {out_num[31:0], out_inst}, {32'd150, 32'h0000_A083});
      @(negedge clock);
    end
    out_ready = 1'b1;
    chk("bp handshake cycle in_ready", 64'({out_valid, in_ready}), 64'b10);
    @(negedge clock);
    chk("bp after handshake", 64'({out_valid, in_ready}), 64'b01);

    // Reset while waiting for read data.
    accept(32'h0000_A083, 32'h8000_0030, 32'h0, 60);
    @(negedge clock);
    chk("rst pre rready", 64'(mem_rready), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst mid-load", 64'({out_valid, mem_rready, mem_arvalid, in_ready}), 64'b0001);
    chk("rst mid-load wdata", 64'(out_wdata), 64'd0);
    run_vec(vecs[0], 61);

`ifdef LSU_ACCESS_FAULT_EN
    accept(32'h0000_A083, 32'h8000_0020, 32'h0, 70);
    serve(32'hFFFF_FFFF, 2'b10, lat);
    chk("fault out_valid", 64'(out_valid), 64'd1);
    chk("fault out_fault", 64'(out_fault), 64'd1);
    chk("fault out_wdata", 64'(out_wdata), 64'd0);
    @(negedge clock);
    run_vec(vecs[0], 71);
    chk("fault cleared", 64'(out_fault), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
